// File: rtl/prores_hdr_pkg.sv
// Shared ProRes header definitions: quant-matrix constants, storage type and parser states.
package prores_hdr_pkg;

  localparam int unsigned QMAT_DEFAULT = 4;
  localparam int unsigned QMAT_MIN     = 2;
  localparam int unsigned QMAT_MAX     = 63;
  localparam int unsigned QMAT_ENTRIES = 64;
  localparam int unsigned QMAT_DIM     = 8;
  localparam int unsigned QMAT_W       = 32;
  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned IDX_W        = $clog2(QMAT_ENTRIES);

  // Row-major 8x8 matrix of 32-bit weights: m[row][col].
  typedef logic [QMAT_DIM-1:0][QMAT_DIM-1:0][QMAT_W-1:0] qmat_t;

  localparam qmat_t QMAT_RESET = {QMAT_ENTRIES{QMAT_W'(QMAT_DEFAULT)}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LUMA   = 3'd1,
    ST_CHROMA = 3'd2,
    ST_COPY   = 3'd3,
    ST_DONE   = 3'd4
  } parser_state_e;

endpackage

// File: rtl/matrix_parser_if.sv
// Byte-stream and control handshake between a header source and the quant-matrix parser.
interface matrix_parser_if;
  import prores_hdr_pkg::*;

  logic              start;
  logic              load_luma;
  logic              load_chroma;
  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    output start, load_luma, load_chroma, in_valid, in_data,
    input  in_ready, busy, done, error
  );

  modport slave (
    input  start, load_luma, load_chroma, in_valid, in_data,
    output in_ready, busy, done, error
  );

endinterface

// File: rtl/matrix_parser.sv
// Parses one quant-matrix header section: optional 64 luma bytes, optional 64 chroma bytes,
// with luma defaulting to 4 and chroma inheriting luma when absent.
module matrix_parser
  import prores_hdr_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  matrix_parser_if.slave  bus,
  output qmat_t           Y_QMAT,
  output qmat_t           C_QMAT
);

  parser_state_e    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             chroma_q, chroma_d;
  logic             error_q, error_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  qmat_t            y_qmat_q, y_qmat_d;
  qmat_t            c_qmat_q, c_qmat_d;

  logic accept_c;
  logic last_c;
  logic range_err_c;

  assign accept_c    = bus.in_valid && in_ready_q;
  assign last_c      = (idx_q == IDX_W'(QMAT_ENTRIES - 1));
  assign range_err_c = (bus.in_data < BYTE_W'(QMAT_MIN)) || (bus.in_data > BYTE_W'(QMAT_MAX));

  // Next-state, matrix write and status decode.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    chroma_d = chroma_q;
    error_d  = error_q;
    y_qmat_d = y_qmat_q;
    c_qmat_d = c_qmat_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          chroma_d = bus.load_chroma;
          error_d  = 1'b0;
          idx_d    = '0;
          // The LUMA state itself records load_luma; an absent luma matrix takes the default.
          if (!bus.load_luma) y_qmat_d = QMAT_RESET;
          if (bus.load_luma)        state_d = ST_LUMA;
          else if (bus.load_chroma) state_d = ST_CHROMA;
          else                      state_d = ST_COPY;
        end
      end
      ST_LUMA: begin
        if (accept_c) begin
          y_qmat_d[idx_q[5:3]][idx_q[2:0]] = QMAT_W'(bus.in_data);
          if (range_err_c) error_d = 1'b1;
          idx_d = idx_q + IDX_W'(1);
          if (last_c) state_d = chroma_q ? ST_CHROMA : ST_COPY;
        end
      end
      ST_CHROMA: begin
        if (accept_c) begin
          c_qmat_d[idx_q[5:3]][idx_q[2:0]] = QMAT_W'(bus.in_data);
          if (range_err_c) error_d = 1'b1;
          idx_d = idx_q + IDX_W'(1);
          if (last_c) state_d = ST_DONE;
        end
      end
      ST_COPY: begin
        c_qmat_d = y_qmat_q;
        state_d  = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_LUMA) || (state_d == ST_CHROMA);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      chroma_q   <= 1'b0;
      error_q    <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      y_qmat_q   <= QMAT_RESET;
      c_qmat_q   <= QMAT_RESET;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      chroma_q   <= chroma_d;
      error_q    <= error_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      y_qmat_q   <= y_qmat_d;
      c_qmat_q   <= c_qmat_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.error    = error_q;
  assign Y_QMAT       = y_qmat_q;
  assign C_QMAT       = c_qmat_q;

endmodule
